// File: rtl/ps2_player_controls_if.sv
// ---------------------------------------------------------------------------
// ps2_player_controls_if
//   Groups the scan-code input stream, the per-player control outputs and the
//   fire acknowledges between the keyboard receiver, ps2_player_controls and
//   the game FSM.
//
// Handshake semantics:
//   scan_code is valid only in a cycle where scan_code_ready is high; each
//   high cycle carries exactly one byte and there is no backpressure.
//   pN_fire_req is a sticky level request; the consumer pulses pN_fire_ack
//   for one or more cycles to clear it. A new fire-key press in the same
//   cycle as an ack keeps the request high.
//
// Signals:
//   scan_code        8  byte from the keyboard receiver
//   scan_code_ready  1  one-cycle strobe per received byte
//   p1_dir           4  player 1 held directions {up, down, left, right}
//   p2_dir           4  player 2 held directions {up, down, left, right}
//   p1_fire_req      1  sticky player 1 fire request
//   p2_fire_req      1  sticky player 2 fire request
//   p1_fire_ack      1  clears p1_fire_req
//   p2_fire_ack      1  clears p2_fire_req
//   dbg_state        2  current prefix FSM state (debug visibility)
//
// Modports:
//   master - drives the scan-code stream and acks (receiver + game FSM side)
//   slave  - ps2_player_controls itself
// ---------------------------------------------------------------------------
interface ps2_player_controls_if;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic [3:0] p1_dir;
    logic [3:0] p2_dir;
    logic       p1_fire_req;
    logic       p2_fire_req;
    logic       p1_fire_ack;
    logic       p2_fire_ack;
    logic [1:0] dbg_state;

    modport master (
        output scan_code,
        output scan_code_ready,
        output p1_fire_ack,
        output p2_fire_ack,
        input  p1_dir,
        input  p2_dir,
        input  p1_fire_req,
        input  p2_fire_req,
        input  dbg_state
    );

    modport slave (
        input  scan_code,
        input  scan_code_ready,
        input  p1_fire_ack,
        input  p2_fire_ack,
        output p1_dir,
        output p2_dir,
        output p1_fire_req,
        output p2_fire_req,
        output dbg_state
    );
endinterface

// File: rtl/ps2_player_controls.sv
// ---------------------------------------------------------------------------
// ps2_player_controls
//   Converts a PS/2 Set-2 scan-code stream (make, break, E0-extended) into
//   per-player held-direction levels and sticky fire requests.
//
//   Player 1: arrow keys (extended codes), fire = Enter or keypad Enter.
//   Player 2: W/S/A/D, fire = Space.
//
// Ports:
//   clk    - system clock (50 MHz)
//   reset  - asynchronous, active-high reset
//   bus    - ps2_player_controls_if.slave (scan-code stream, directions,
//            fire requests/acks, debug state)
//
// Parameters:
//   STUCK_TIMEOUT - idle clk cycles (no scan_code_ready) after which held
//                   keys are force-released; only used when the macro
//                   KEY_STUCK_CLEAR_EN is defined.
//
// Build option:
//   `define KEY_STUCK_CLEAR_EN enables the stuck-key timeout. Without it the
//   held bits change only on decoded codes and reset.
// ---------------------------------------------------------------------------
module ps2_player_controls #(
    parameter int unsigned STUCK_TIMEOUT = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_player_controls_if.slave   bus
);

    // Held-key vector layout. The low byte is laid out so that each nibble is
    // directly a {up, down, left, right} direction group.
    localparam int HELD_W     = 11;
    localparam int K_RIGHT    = 0;
    localparam int K_LEFT     = 1;
    localparam int K_DOWN     = 2;
    localparam int K_UP       = 3;
    localparam int K_D        = 4;
    localparam int K_A        = 5;
    localparam int K_S        = 6;
    localparam int K_W        = 7;
    localparam int K_SPACE    = 8;
    localparam int K_ENTER    = 9;
    localparam int K_KP_ENTER = 10;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    prefix_state_t     state_q, state_d;
    logic [HELD_W-1:0] held_q, held_d;
    logic [3:0]        p1_dir_q, p1_dir_d;
    logic [3:0]        p2_dir_q, p2_dir_d;
    logic              p1_fire_q, p1_fire_d;
    logic              p2_fire_q, p2_fire_d;

    logic              code_done;
    logic              code_ext;
    logic              code_brk;
    logic [HELD_W-1:0] key_mask;
    logic [HELD_W-1:0] new_press;
    logic              p1_set;
    logic              p2_set;
    logic              stuck_clear;

    // One-hot held bit for a completed code; unmapped codes give zero.
    function automatic logic [HELD_W-1:0] decode_key(input logic ext, input logic [7:0] code);
        logic [HELD_W-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                8'h75:   m[K_UP]       = 1'b1;
                8'h72:   m[K_DOWN]     = 1'b1;
                8'h6B:   m[K_LEFT]     = 1'b1;
                8'h74:   m[K_RIGHT]    = 1'b1;
                8'h5A:   m[K_KP_ENTER] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h1D:   m[K_W]     = 1'b1;
                8'h1B:   m[K_S]     = 1'b1;
                8'h1C:   m[K_A]     = 1'b1;
                8'h23:   m[K_D]     = 1'b1;
                8'h29:   m[K_SPACE] = 1'b1;
                8'h5A:   m[K_ENTER] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    // Opposing directions cancel at the output; held bits stay intact so
    // releasing one of the pair restores the other direction.
    function automatic logic [3:0] cancel_opposing(input logic [3:0] d);
        return {d[3] & ~d[2], d[2] & ~d[3], d[1] & ~d[0], d[0] & ~d[1]};
    endfunction

`ifdef KEY_STUCK_CLEAR_EN
    localparam logic [25:0] TIMEOUT_VAL = 26'(STUCK_TIMEOUT);

    logic [25:0] stuck_cnt_q;

    // Saturating idle counter: restarts on every received byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stuck_cnt_q <= '0;
        end else if (bus.scan_code_ready) begin
            stuck_cnt_q <= '0;
        end else if (stuck_cnt_q != '1) begin
            stuck_cnt_q <= stuck_cnt_q + 26'd1;
        end
    end

    assign stuck_clear = !bus.scan_code_ready && (stuck_cnt_q == TIMEOUT_VAL) && (|held_q);
`else
    assign stuck_clear = 1'b0;
`endif

    // State / output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            held_q    <= '0;
            p1_dir_q  <= '0;
            p2_dir_q  <= '0;
            p1_fire_q <= 1'b0;
            p2_fire_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            p1_dir_q  <= p1_dir_d;
            p2_dir_q  <= p2_dir_d;
            p1_fire_q <= p1_fire_d;
            p2_fire_q <= p2_fire_d;
        end
    end

    // Prefix FSM, key decode and fire-request next state
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        code_done = 1'b0;
        code_ext  = 1'b0;
        code_brk  = 1'b0;
        key_mask  = '0;
        new_press = '0;
        p1_set    = 1'b0;
        p2_set    = 1'b0;

        if (bus.scan_code_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.scan_code == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        code_done = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.scan_code == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.scan_code != CODE_EXT) begin
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (bus.scan_code == CODE_EXT) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.scan_code != CODE_BRK) begin
                        code_done = 1'b1;
                        code_brk  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if ((bus.scan_code != CODE_EXT) && (bus.scan_code != CODE_BRK)) begin
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                        code_brk  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (code_done) begin
            key_mask = decode_key(code_ext, bus.scan_code);
            if (code_brk) begin
                held_d = held_q & ~key_mask;
            end else begin
                held_d    = held_q | key_mask;
                // Only a 0->1 transition of a fire key arms a request, so
                // typematic repeats do not re-fire.
                new_press = key_mask & ~held_q;
                p1_set    = new_press[K_ENTER] | new_press[K_KP_ENTER];
                p2_set    = new_press[K_SPACE];
            end
        end

        // Only reachable in an idle cycle, so it never races a decode.
        if (stuck_clear) begin
            held_d  = '0;
            state_d = ST_IDLE;
        end

        p1_dir_d  = cancel_opposing(held_d[3:0]);
        p2_dir_d  = cancel_opposing(held_d[7:4]);
        // Set has priority over ack.
        p1_fire_d = p1_set | (p1_fire_q & ~bus.p1_fire_ack);
        p2_fire_d = p2_set | (p2_fire_q & ~bus.p2_fire_ack);
    end

    assign bus.p1_dir      = p1_dir_q;
    assign bus.p2_dir      = p2_dir_q;
    assign bus.p1_fire_req = p1_fire_q;
    assign bus.p2_fire_req = p2_fire_q;
    assign bus.dbg_state   = state_q;

endmodule
